// File: rtl/uart_word_link.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_link
// Purpose  : Multi-byte word link over a single UART tx/rx pair. A TX word
//            FIFO feeds an 8N1 serialiser (LSB byte first). An oversampled
//            deserialiser assembles bytes into words and pushes them into an
//            RX word FIFO. Both FIFOs use valid/ready handshakes.
// Options  : UART_WORD_PARITY_EN - adds an even-parity bit after the data
//            bits on TX and checks it on RX (11 bits per byte).
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_link #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BYTES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [8*DATA_BYTES-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [8*DATA_BYTES-1:0] rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    tx,
    input  logic                    rx,
    output logic                    tx_busy,
    output logic                    rx_frame_err,
    output logic                    rx_overflow
);
    localparam int W  = 8 * DATA_BYTES;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLK_DIV);
    localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_WORD_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // ---------------- TX FIFO ----------------
    logic [W-1:0]  txf_mem_q [FIFO_DEPTH];
    logic [AW-1:0] txf_wr_q, txf_wr_d, txf_rd_q, txf_rd_d;
    logic [CW-1:0] txf_cnt_q, txf_cnt_d;
    logic          w_txf_push, w_txf_pop;

    // ---------------- TX serialiser ----------------
    logic [2:0]    tx_state_q, tx_state_d;
    logic [BW-1:0] tx_baud_q, tx_baud_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [IW-1:0] tx_byte_q, tx_byte_d;
    logic [W-1:0]  tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d;
    logic          w_tx_baud_end;
`ifdef UART_WORD_PARITY_EN
    logic          tx_par_q, tx_par_d;
`endif

    assign tx_ready   = (txf_cnt_q < CW'(FIFO_DEPTH));
    assign w_txf_push = tx_valid & tx_ready;
    assign w_txf_pop  = (tx_state_q == S_IDLE) && (txf_cnt_q != '0);
    assign tx         = tx_q;
    assign tx_busy    = (tx_state_q != S_IDLE);

    // TX FIFO pointer/count update
    always_comb begin
        txf_wr_d  = w_txf_push ? txf_wr_q + AW'(1) : txf_wr_q;
        txf_rd_d  = w_txf_pop  ? txf_rd_q + AW'(1) : txf_rd_q;
        txf_cnt_d = txf_cnt_q;
        if (w_txf_push && !w_txf_pop)
            txf_cnt_d = txf_cnt_q + CW'(1);
        else if (!w_txf_push && w_txf_pop)
            txf_cnt_d = txf_cnt_q - CW'(1);
    end

    // TX serialiser next state; tx line is registered from the next state
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_baud_d     = tx_baud_q;
        tx_bit_d      = tx_bit_q;
        tx_byte_d     = tx_byte_q;
        tx_sh_d       = tx_sh_q;
`ifdef UART_WORD_PARITY_EN
        tx_par_d      = tx_par_q;
`endif
        w_tx_baud_end = (tx_baud_q == BW'(CLK_DIV - 1));
        if (tx_state_q != S_IDLE)
            tx_baud_d = w_tx_baud_end ? '0 : tx_baud_q + BW'(1);
        case (tx_state_q)
            S_IDLE: begin
                if (w_txf_pop) begin
                    tx_sh_d    = txf_mem_q[txf_rd_q];
                    tx_byte_d  = '0;
                    tx_baud_d  = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (w_tx_baud_end) begin
                    tx_bit_d   = 3'd0;
`ifdef UART_WORD_PARITY_EN
                    tx_par_d   = 1'b0;
`endif
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tx_baud_end) begin
                    // whole word shifts so the next byte lands in bits [7:0]
                    tx_sh_d  = tx_sh_q >> 1;
`ifdef UART_WORD_PARITY_EN
                    tx_par_d = tx_par_q ^ tx_sh_q[0];
`endif
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_WORD_PARITY_EN
                        tx_state_d = S_PARITY;
`else
                        tx_state_d = S_STOP;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_WORD_PARITY_EN
            S_PARITY: begin
                if (w_tx_baud_end)
                    tx_state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tx_baud_end) begin
                    if (tx_byte_q == IW'(DATA_BYTES - 1)) begin
                        tx_state_d = S_IDLE;
                    end else begin
                        tx_byte_d  = tx_byte_q + IW'(1);
                        tx_state_d = S_START;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_sh_d[0];
`ifdef UART_WORD_PARITY_EN
            S_PARITY: tx_d = tx_par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // ---------------- RX path ----------------
    logic [W-1:0]  rxf_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rxf_wr_q, rxf_wr_d, rxf_rd_q, rxf_rd_d;
    logic [CW-1:0] rxf_cnt_q, rxf_cnt_d;
    logic          w_rxf_push, w_rxf_pop, w_word_done, w_rx_space;

    logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    logic [2:0]    rx_state_q, rx_state_d;
    logic [BW-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [IW-1:0] rx_byte_q, rx_byte_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [W-1:0]  rx_word_q, rx_word_d;
    logic          rx_armed_q, rx_armed_d;
    logic          rx_ferr_q, rx_ferr_d, rx_ovf_q, rx_ovf_d;
    logic          w_rx_samp, w_par_bad;
`ifdef UART_WORD_PARITY_EN
    logic          rx_perr_q, rx_perr_d;
    assign w_par_bad = rx_perr_q;
`else
    assign w_par_bad = 1'b0;
`endif

    assign rx_valid     = (rxf_cnt_q != '0);
    assign rx_data      = rx_valid ? rxf_mem_q[rxf_rd_q] : '0;
    assign rx_frame_err = rx_ferr_q;
    assign rx_overflow  = rx_ovf_q;
    assign w_rxf_pop    = rx_valid & rx_ready;
    // a same-cycle pop frees the slot the new word needs
    assign w_rx_space   = (rxf_cnt_q < CW'(FIFO_DEPTH)) || w_rxf_pop;
    assign w_rxf_push   = w_word_done & w_rx_space;

    // RX deserialiser, word assembly and RX FIFO bookkeeping
    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        rx_state_d  = rx_state_q;
        rx_baud_d   = rx_baud_q;
        rx_bit_d    = rx_bit_q;
        rx_byte_d   = rx_byte_q;
        rx_sh_d     = rx_sh_q;
        rx_word_d   = rx_word_q;
        rx_armed_d  = rx_armed_q;
        rx_ferr_d   = 1'b0;
        w_word_done = 1'b0;
`ifdef UART_WORD_PARITY_EN
        rx_perr_d   = rx_perr_q;
`endif
        w_rx_samp   = (rx_baud_q == '0);
        if (rx_state_q != S_IDLE && !w_rx_samp)
            rx_baud_d = rx_baud_q - BW'(1);
        case (rx_state_q)
            S_IDLE: begin
                // a start is only accepted after the line was seen high
                if (rx_sync_q) begin
                    rx_armed_d = 1'b1;
                end else if (rx_armed_q) begin
                    rx_armed_d = 1'b0;
                    rx_baud_d  = BW'(CLK_DIV / 2 - 1);
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (w_rx_samp) begin
                    if (!rx_sync_q) begin
                        rx_baud_d  = BW'(CLK_DIV - 1);
                        rx_bit_d   = 3'd0;
                        rx_state_d = S_DATA;
                    end else begin
                        rx_state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_rx_samp) begin
                    rx_sh_d   = {rx_sync_q, rx_sh_q[7:1]};
                    rx_baud_d = BW'(CLK_DIV - 1);
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_WORD_PARITY_EN
                        rx_state_d = S_PARITY;
`else
                        rx_state_d = S_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_WORD_PARITY_EN
            S_PARITY: begin
                if (w_rx_samp) begin
                    rx_perr_d  = rx_sync_q ^ (^rx_sh_q);
                    rx_baud_d  = BW'(CLK_DIV - 1);
                    rx_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_rx_samp) begin
                    rx_state_d = S_IDLE;
`ifdef UART_WORD_PARITY_EN
                    rx_perr_d  = 1'b0;
`endif
                    if (rx_sync_q && !w_par_bad) begin
                        rx_word_d[rx_byte_q*8 +: 8] = rx_sh_q;
                        if (rx_byte_q == IW'(DATA_BYTES - 1)) begin
                            w_word_done = 1'b1;
                            rx_byte_d   = '0;
                        end else begin
                            rx_byte_d = rx_byte_q + IW'(1);
                        end
                    end else begin
                        rx_ferr_d = 1'b1;
                        rx_byte_d = '0;
                        rx_word_d = '0;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase

        rx_ovf_d  = w_word_done & ~w_rx_space;
        rxf_wr_d  = w_rxf_push ? rxf_wr_q + AW'(1) : rxf_wr_q;
        rxf_rd_d  = w_rxf_pop  ? rxf_rd_q + AW'(1) : rxf_rd_q;
        rxf_cnt_d = rxf_cnt_q;
        if (w_rxf_push && !w_rxf_pop)
            rxf_cnt_d = rxf_cnt_q + CW'(1);
        else if (!w_rxf_push && w_rxf_pop)
            rxf_cnt_d = rxf_cnt_q - CW'(1);
    end

    // FIFO storage: contents are don't-care until the count covers them
    always_ff @(posedge clock) begin
        if (w_txf_push) txf_mem_q[txf_wr_q] <= tx_data;
        if (w_rxf_push) rxf_mem_q[rxf_wr_q] <= rx_word_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            txf_wr_q   <= '0;
            txf_rd_q   <= '0;
            txf_cnt_q  <= '0;
            tx_state_q <= S_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_WORD_PARITY_EN
            tx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
            rxf_wr_q   <= '0;
            rxf_rd_q   <= '0;
            rxf_cnt_q  <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_sh_q    <= '0;
            rx_word_q  <= '0;
            rx_armed_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovf_q   <= 1'b0;
        end else begin
            txf_wr_q   <= txf_wr_d;
            txf_rd_q   <= txf_rd_d;
            txf_cnt_q  <= txf_cnt_d;
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
`ifdef UART_WORD_PARITY_EN
            tx_par_q   <= tx_par_d;
            rx_perr_q  <= rx_perr_d;
`endif
            rxf_wr_q   <= rxf_wr_d;
            rxf_rd_q   <= rxf_rd_d;
            rxf_cnt_q  <= rxf_cnt_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            rx_sh_q    <= rx_sh_d;
            rx_word_q  <= rx_word_d;
            rx_armed_q <= rx_armed_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovf_q   <= rx_ovf_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_word_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_link
// Purpose  : Directed self-checking bench for uart_word_link with a word
//            scoreboard, line decoding and pulse monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_link;
    localparam int CLK_DIV    = 16;
    localparam int DATA_BYTES = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_WORD_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME = DATA_BYTES * BITS * CLK_DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        rx_ready = 1'b0;
    logic        tx_ready, rx_valid, tx, tx_busy, rx_frame_err, rx_overflow;
    logic [31:0] rx_data;
    logic        loop_en = 1'b1;
    logic        bench_rx = 1'b1;
    logic        w_rx;

    assign w_rx = loop_en ? tx : bench_rx;

    uart_word_link #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BYTES(DATA_BYTES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx          (tx),
        .rx          (w_rx),
        .tx_busy     (tx_busy),
        .rx_frame_err(rx_frame_err),
        .rx_overflow (rx_overflow)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          rise_cyc = -1;
    logic        prev_valid = 1'b0;
    logic [31:0] sb [$];

    // pulse counters and cycle count
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rx_frame_err) fe_cnt <= fe_cnt + 1;
        if (rx_overflow)  ov_cnt <= ov_cnt + 1;
    end

    // record the cycle of every rx_valid rising edge
    always @(negedge clock) begin
        prev_valid <= rx_valid;
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        int n = 0;
        while (!tx_ready && n < 5000) begin
            tick(1);
            n++;
        end
        check("push_ready", {31'd0, tx_ready}, 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        if (tx_ready) sb.push_back(w);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic get_word(input string tag, input int budget);
        int          n = 0;
        logic [31:0] exp;
        while (!rx_valid && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        if (rx_valid) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
            check(tag, rx_data, exp);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bench_rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            bench_rx = b[i];
            tick(CLK_DIV);
        end
`ifdef UART_WORD_PARITY_EN
        bench_rx = ^b;
        tick(CLK_DIV);
`endif
        bench_rx = stop;
        tick(CLK_DIV);
        bench_rx = 1'b1;
    endtask

    task automatic send_word_raw(input logic [31:0] w);
        for (int i = 0; i < DATA_BYTES; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic decode_byte(input string tag, input logic [7:0] exp);
        int         n = 0;
        logic [7:0] b;
        while (tx !== 1'b0 && n < 64) begin
            tick(1);
            n++;
        end
        tick(CLK_DIV / 2);
        check({tag, "_start"}, {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(CLK_DIV);
            b[i] = tx;
        end
`ifdef UART_WORD_PARITY_EN
        tick(CLK_DIV);
        check({tag, "_parity"}, {31'd0, tx}, {31'd0, ^exp});
`endif
        tick(CLK_DIV);
        check({tag, "_stop"}, {31'd0, tx}, 32'd1);
        check(tag, {24'd0, b}, {24'd0, exp});
    endtask

    int push_cyc, lat, fe0, ov0, acc, n;

    initial begin
        // ---- reset state ----
        tick(3);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("rst_overflow", {31'd0, rx_overflow}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        reset = 1'b0;
        tick(4);

        // ---- loopback of one word ----
        push_word(32'hDEADBEEF);
        push_cyc = cyc;
        decode_byte("line_b0", 8'hEF);
        decode_byte("line_b1", 8'hBE);
        decode_byte("line_b2", 8'hAD);
        decode_byte("line_b3", 8'hDE);
        get_word("loop_word", 100);
        lat = rise_cyc - push_cyc;
        checks++;
        assert (lat >= FRAME - 4 && lat <= FRAME + 4) else begin
            errors++;
            $error("FAIL loop_latency observed=%0d expected=%0d+-4", lat, FRAME);
        end
        n = 0;
        while (tx_busy && n < 40) begin
            tick(1);
            n++;
        end
        check("loop_busy_fall", {31'd0, tx_busy}, 32'd0);
        check("loop_tx_idle", {31'd0, tx}, 32'd1);

        // ---- TX back-pressure ----
        tick(10);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tx_data  = 32'(i + 1);
            tx_valid = 1'b1;
            if (tx_ready) begin
                sb.push_back(32'(i + 1));
                acc++;
            end
            tick(1);
        end
        check("bp_ready_low", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd5);
        for (int i = 0; i < 5; i++) get_word("bp_word", 2 * FRAME);

        // ---- RX overflow ----
        tick(20);
        ov0 = ov_cnt;
        for (int i = 0; i < 5; i++) push_word(32'(i + 1));
        void'(sb.pop_back());
        tick(5 * FRAME + 100);
        check("ovf_pulses", 32'(ov_cnt - ov0), 32'd1);
        check("ovf_valid", {31'd0, rx_valid}, 32'd1);
        for (int i = 0; i < 4; i++) get_word("ovf_drain", 10);
        tick(2);
        check("ovf_empty", {31'd0, rx_valid}, 32'd0);

        // ---- frame error on byte 2 ----
        loop_en = 1'b0;
        tick(20);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        tick(3 * CLK_DIV);
        check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
        check("ferr_no_ovf", 32'(ov_cnt - ov0), 32'd0);
        send_word_raw(32'h12345678);
        sb.push_back(32'h12345678);
        get_word("ferr_next_word", 200);

        // ---- start-bit glitch ----
        tick(20);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        bench_rx = 1'b0;
        tick(4);
        bench_rx = 1'b1;
        tick(40);
        check("glitch_no_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("glitch_no_ovf", 32'(ov_cnt - ov0), 32'd0);
        check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        send_word_raw(32'hA5C30F96);
        sb.push_back(32'hA5C30F96);
        get_word("glitch_next_word", 200);

        // ---- reset mid-frame ----
        loop_en = 1'b1;
        tick(10);
        push_word(32'hCAFEF00D);
        tick(BITS * CLK_DIV + 3 * CLK_DIV);
        check("mid_busy", {31'd0, tx_busy}, 32'd1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        reset = 1'b0;
        sb.delete();
        tick(5 * CLK_DIV);
        check("mid_no_stale_word", {31'd0, rx_valid}, 32'd0);
        push_word(32'h0BADC0DE);
        get_word("mid_fresh_word", FRAME + 50);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
